axis_flit_deserializer: RTL and testbench
=========================================

AXIS_FLIT_DESERIALIZER -- requirements
Module: axis_flit_deserializer

Interface
REQ-001 Parameter TDEST_WIDTH, default 6: width of the flit destination field and of axis_tdest.
REQ-002 Parameter TDATA_WIDTH, default 512: AXIS beat width.
REQ-003 Parameter SERIALIZATION_FACTOR, default 4: flits per full beat; must be at least 1 and must divide TDATA_WIDTH.
REQ-004 Parameter FLIT_BUFFER_DEPTH, default 4: flit FIFO depth, equal to the credits held by the upstream sender; must be at least 2.
REQ-005 Local constant FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR.
REQ-006 clk  in  1  single clock for all logic.
REQ-007 rst_n  in  1  reset, synchronous and active-low.
REQ-008 data_in  in  FLIT_WIDTH  flit payload.
REQ-009 dest_in  in  TDEST_WIDTH  flit destination.
REQ-010 is_tail_in  in  1  flit is the last flit of its packet.
REQ-011 send_in  in  1  flit valid this cycle (credit-based, no backpressure).
REQ-012 credit_out  out  1  one-cycle pulse returning one credit.
REQ-013 axis_tvalid  out  1  beat valid.
REQ-014 axis_tready  in  1  sink accepts the beat.
REQ-015 axis_tdata  out  TDATA_WIDTH  assembled beat.
REQ-016 axis_tlast  out  1  beat ends the packet.
REQ-017 axis_tdest  out  TDEST_WIDTH  beat destination.
REQ-018 overflow_err  out  1  sticky flag: a flit arrived while the FIFO was full.

Function
REQ-019 The flit FIFO SHALL write {data_in, dest_in, is_tail_in} on every cycle with send_in=1 while not full; a flit written in cycle t is poppable in cycle t+1 at the earliest.
REQ-020 A send_in while full SHALL drop the flit and set overflow_err, which stays set until reset.
REQ-021 Each FIFO pop SHALL cause exactly one credit_out pulse, registered one cycle after the pop.
REQ-022 Simultaneous push and pop on a full FIFO SHALL be accepted.
REQ-023 The assembler SHALL have two states:
- COLLECT: counts 0..SERIALIZATION_FACTOR-1.
- EMIT: represents the output register being occupied.
REQ-024 Flits SHALL fill the beat LSB-first: flit k lands in bits [k*FLIT_WIDTH +: FLIT_WIDTH].
REQ-025 axis_tdest SHALL be taken from the first flit of each beat; dest_in on later flits of the same beat is ignored.
REQ-026 A beat SHALL close on whichever comes first:
- the count reaching SERIALIZATION_FACTOR-1, or
- a flit with is_tail_in=1.
REQ-027 On beat close: axis_tlast = is_tail of the closing flit, unfilled upper slices are zero, and the count returns to 0.
REQ-028 The closing flit SHALL be popped only when the output register is free (axis_tvalid=0, or axis_tready=1 in the same cycle); otherwise popping stalls.
REQ-029 Non-closing flits SHALL pop whenever the FIFO is non-empty, regardless of the output state.
REQ-030 Latency: with the output free, the closing flit is popped in cycle t and axis_tvalid=1 in cycle t+1.
REQ-031 Sustained throughput SHALL be one flit per cycle, with back-to-back beats under continuous axis_tready.
REQ-032 While axis_tvalid=1 and axis_tready=0, axis_tdata, axis_tlast and axis_tdest SHALL remain stable.
REQ-033 With SERIALIZATION_FACTOR=1, every flit SHALL be a complete beat.

Reset
REQ-034 rst_n=0, sampled at a clk edge, SHALL clear:
- the FIFO, count and state (to COLLECT);
- axis_tvalid, credit_out and overflow_err to 0;
- axis_tdata, axis_tlast and axis_tdest to 0.
REQ-035 Reset mid-packet SHALL discard any partial beat and all buffered flits, and SHALL NOT return credits for them.

Structure
REQ-036 The flit record typedef (data, dest, is_tail) and the FLIT_WIDTH derivation SHALL live in the shared NoC package.
REQ-037 The FIFO SHALL be a separate sub-module, flit_fifo; the assembler and output register stay in this module.

Verification
REQ-038 Bench configuration: TDATA_WIDTH=32, SERIALIZATION_FACTOR=4, FLIT_BUFFER_DEPTH=4, TDEST_WIDTH=6.
REQ-039 The bench SHALL cover:
- Flits 0x11, 0x22, 0x33, 0x44 (last one tail, dest 5) on consecutive cycles, tready=1 -> one beat tdata=0x44332211, tlast=1, tdest=5; tvalid asserted 2 cycles after the last send; 4 credit pulses total.
- Tail on the 2nd flit (0xAA, 0xBB) -> tdata=0x0000BBAA, tlast=1.
- tready=0, 8 flits sent using 4 credits then waiting for returns -> the first beat is held stable; no more than 4 flits are outstanding; the second beat follows in the cycle after the first handshake.
- 5 sends without any credit return while tready=0 -> overflow_err=1 and the 5th flit is dropped.
- rst_n=0 after 2 flits of a beat -> tvalid=0 and no credit pulses; a following full packet assembles correctly from count 0.
- Continuous random flits with tready=1 -> one beat every 4 cycles and data matching a reference model.

Source files
------------

// File: rtl/axis_flit_deserializer_pkg.sv
// Shared NoC definitions: the flit record, the assembler state encoding and the
// flit-width derivation used by the deserializer and its FIFO.
package axis_flit_deserializer_pkg;

    // The flit record is sized for the widest flit on the NoC. Narrower
    // configurations leave the upper field bits at zero.
    localparam int unsigned NOC_MAX_FLIT_WIDTH = 512;
    localparam int unsigned NOC_MAX_DEST_WIDTH = 16;

    typedef struct packed {
        logic [NOC_MAX_FLIT_WIDTH-1:0] data;
        logic [NOC_MAX_DEST_WIDTH-1:0] dest;
        logic                          is_tail;
    } flit_t;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } asm_state_e;

    function automatic int unsigned flit_width(input int unsigned tdata_width,
                                               input int unsigned ser_factor);
        return tdata_width / ser_factor;
    endfunction

endpackage

// File: rtl/axis_flit_deserializer_fifo.sv
// Credit-sized flit FIFO: registered storage, so a flit written in one cycle
// can be popped from the next cycle on.
module flit_fifo
    import axis_flit_deserializer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  flit_t wr_flit,
    input  logic  pop,
    output flit_t rd_flit,
    output logic  empty,
    output logic  full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    flit_t            mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign rd_flit = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_flit;
        end
    end

endmodule

// File: rtl/axis_flit_deserializer.sv
// Credit-based flit receiver that packs SERIALIZATION_FACTOR flits (or fewer,
// when a tail arrives early) LSB-first into one AXI-Stream beat.
module axis_flit_deserializer
    import axis_flit_deserializer_pkg::*;
#(
    parameter int unsigned TDEST_WIDTH          = 6,
    parameter int unsigned TDATA_WIDTH          = 512,
    parameter int unsigned SERIALIZATION_FACTOR = 4,
    parameter int unsigned FLIT_BUFFER_DEPTH    = 4,
    localparam int unsigned FLIT_WIDTH          = flit_width(TDATA_WIDTH, SERIALIZATION_FACTOR)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [TDEST_WIDTH-1:0] dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic                   axis_tvalid,
    input  logic                   axis_tready,
    output logic [TDATA_WIDTH-1:0] axis_tdata,
    output logic                   axis_tlast,
    output logic [TDEST_WIDTH-1:0] axis_tdest,
    output logic                   overflow_err
);

    localparam int unsigned CNT_W = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SERIALIZATION_FACTOR - 1);

    flit_t wr_flit;
    flit_t rd_flit;
    flit_t unused_rd_flit;
    logic  fifo_empty;
    logic  fifo_full;
    logic  fifo_pop;

    asm_state_e             state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [TDATA_WIDTH-1:0] acc_data_q, acc_data_d;
    logic [TDEST_WIDTH-1:0] acc_dest_q, acc_dest_d;
    logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                   tlast_q, tlast_d;
    logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
    logic                   credit_q, credit_d;
    logic                   overflow_q, overflow_d;

    logic                   out_free;
    logic                   head_closes;
    logic [FLIT_WIDTH-1:0]  head_data;
    logic [TDEST_WIDTH-1:0] head_dest;
    logic [TDATA_WIDTH-1:0] beat_data;
    logic [TDEST_WIDTH-1:0] beat_dest;

    always_comb begin
        wr_flit                         = '0;
        wr_flit.data[FLIT_WIDTH-1:0]    = data_in;
        wr_flit.dest[TDEST_WIDTH-1:0]   = dest_in;
        wr_flit.is_tail                 = is_tail_in;
    end

    flit_fifo #(
        .DEPTH (FLIT_BUFFER_DEPTH)
    ) u_flit_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (send_in),
        .wr_flit (wr_flit),
        .pop     (fifo_pop),
        .rd_flit (rd_flit),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Record bits above the configured widths are always zero on this link.
    assign unused_rd_flit = rd_flit;
    assign head_data      = rd_flit.data[FLIT_WIDTH-1:0];
    assign head_dest      = rd_flit.dest[TDEST_WIDTH-1:0];

    always_comb begin
        out_free    = (state_q == ST_COLLECT) || axis_tready;
        head_closes = (count_q == LAST_SLOT) || rd_flit.is_tail;
        // Only the closing flit needs the output register; the rest keep streaming.
        fifo_pop    = !fifo_empty && (!head_closes || out_free);

        beat_dest = (count_q == '0) ? head_dest : acc_dest_q;
        beat_data = acc_data_q;
        beat_data[count_q*FLIT_WIDTH +: FLIT_WIDTH] = head_data;

        state_d    = state_q;
        count_d    = count_q;
        acc_data_d = acc_data_q;
        acc_dest_d = acc_dest_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        tdest_d    = tdest_q;
        credit_d   = fifo_pop;
        overflow_d = overflow_q || (send_in && fifo_full && !fifo_pop);

        if (state_q == ST_EMIT && axis_tready) begin
            state_d = ST_COLLECT;
        end
        if (fifo_pop) begin
            if (head_closes) begin
                state_d    = ST_EMIT;
                tdata_d    = beat_data;
                tlast_d    = rd_flit.is_tail;
                tdest_d    = beat_dest;
                count_d    = '0;
                acc_data_d = '0;
            end else begin
                acc_data_d = beat_data;
                acc_dest_d = beat_dest;
                count_d    = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_COLLECT;
            count_q    <= '0;
            acc_data_q <= '0;
            acc_dest_q <= '0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            tdest_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_data_q <= acc_data_d;
            acc_dest_q <= acc_dest_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            tdest_q    <= tdest_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    assign axis_tvalid  = (state_q == ST_EMIT);
    assign axis_tdata   = tdata_q;
    assign axis_tlast   = tlast_q;
    assign axis_tdest   = tdest_q;
    assign credit_out   = credit_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_axis_flit_deserializer.sv
// Bench for axis_flit_deserializer: credit-respecting flit driver, packet-level
// reference model feeding an expected-beat queue, and an AXIS monitor.
module tb_axis_flit_deserializer;

    localparam int TDEST_WIDTH = 6;
    localparam int TDATA_WIDTH = 32;
    localparam int SF          = 4;
    localparam int DEPTH       = 4;
    localparam int FW          = TDATA_WIDTH / SF;
    localparam int EXP_W       = 1 + TDEST_WIDTH + TDATA_WIDTH;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [FW-1:0]          data_in = '0;
    logic [TDEST_WIDTH-1:0] dest_in = '0;
    logic                   is_tail_in = 1'b0;
    logic                   send_in = 1'b0;
    logic                   axis_tready = 1'b0;
    logic                   credit_out;
    logic                   axis_tvalid;
    logic [TDATA_WIDTH-1:0] axis_tdata;
    logic                   axis_tlast;
    logic [TDEST_WIDTH-1:0] axis_tdest;
    logic                   overflow_err;

    axis_flit_deserializer #(
        .TDEST_WIDTH          (TDEST_WIDTH),
        .TDATA_WIDTH          (TDATA_WIDTH),
        .SERIALIZATION_FACTOR (SF),
        .FLIT_BUFFER_DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .dest_in      (dest_in),
        .is_tail_in   (is_tail_in),
        .send_in      (send_in),
        .credit_out   (credit_out),
        .axis_tvalid  (axis_tvalid),
        .axis_tready  (axis_tready),
        .axis_tdata   (axis_tdata),
        .axis_tlast   (axis_tlast),
        .axis_tdest   (axis_tdest),
        .overflow_err (overflow_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion by %0t", $time);
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0]       exp_q[$];
    logic [FW-1:0]          part_data[$];
    logic [TDEST_WIDTH-1:0] part_dest = '0;
    int                     hs_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int sent_total = 0;
    int credit_returns = 0;
    int credit_base = 0;
    int last_send_cyc = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    function automatic int avail();
        return DEPTH - sent_total + (credit_returns - credit_base);
    endfunction

    // Packet-level model: gather flits until SF of them or a tail, then emit one beat.
    task automatic model_push(input logic [FW-1:0] d, input logic [TDEST_WIDTH-1:0] dst, input logic tl);
        logic [TDATA_WIDTH-1:0] beat;
        if (part_data.size() == 0) part_dest = dst;
        part_data.push_back(d);
        if (part_data.size() == SF || tl) begin
            beat = '0;
            foreach (part_data[i]) beat = beat | (TDATA_WIDTH'(part_data[i]) << (FW * i));
            exp_q.push_back({tl, part_dest, beat});
            part_data.delete();
        end
    endtask

    // ---------------- monitor ----------------
    logic             hold_valid = 1'b0;
    logic [EXP_W-1:0] held_beat = '0;

    always @(negedge clk) begin
        logic [EXP_W-1:0] now_beat;
        logic [EXP_W-1:0] exp_beat;
        now_beat = {axis_tlast, axis_tdest, axis_tdata};
        if (credit_out) credit_returns++;
        if (!rst_n) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("stall_tvalid", 64'(axis_tvalid), 64'(1));
                check("stall_beat_stable", 64'(now_beat), 64'(held_beat));
            end
            if (axis_tvalid && axis_tready) begin
                hs_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("beat_was_expected", 64'(exp_q.size()), 64'(1));
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat", 64'(now_beat), 64'(exp_beat));
                end
            end
            hold_valid = axis_tvalid && !axis_tready;
            held_beat  = now_beat;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        send_in = 1'b0;
        rst_n   = 1'b0;
        wait_cycles(3);
        exp_q.delete();
        part_data.delete();
        sent_total  = 0;
        credit_base = credit_returns;
        rst_n = 1'b1;
    endtask

    // ignore_credit models a misbehaving sender; accepted says whether the DUT should keep it.
    task automatic send_flit(input logic [FW-1:0] d, input logic [TDEST_WIDTH-1:0] dst,
                             input logic tl, input bit ignore_credit, input bit accepted);
        int waited = 0;
        while (!ignore_credit && avail() <= 0) begin
            wait_cycles(1);
            waited++;
            if (waited > 100) begin
                check("credit_wait", 64'(avail()), 64'(1));
                return;
            end
        end
        data_in    = d;
        dest_in    = dst;
        is_tail_in = tl;
        send_in    = 1'b1;
        if (accepted) begin
            sent_total++;
            model_push(d, dst, tl);
        end
        last_send_cyc = cyc;
        wait_cycles(1);
        send_in    = 1'b0;
        is_tail_in = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tvalid"}, 64'(axis_tvalid), 64'(0));
        check({tag, "_tdata"}, 64'(axis_tdata), 64'(0));
        check({tag, "_tlast"}, 64'(axis_tlast), 64'(0));
        check({tag, "_tdest"}, 64'(axis_tdest), 64'(0));
        check({tag, "_credit"}, 64'(credit_out), 64'(0));
        check({tag, "_overflow"}, 64'(overflow_err), 64'(0));
    endtask

    task automatic wait_handshakes(input int target);
        int guard = 0;
        while (hs_q.size() < target && guard < 200) begin
            wait_cycles(1);
            guard++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cr0;
        int lat;
        int n0;
        logic tl;

        do_reset();
        check_reset_state("reset");

        // Full four-flit packet, tail on the last flit.
        axis_tready = 1'b1;
        cr0 = credit_returns;
        send_flit(8'h11, 6'd5, 1'b0, 1'b0, 1'b1);
        send_flit(8'h22, 6'd5, 1'b0, 1'b0, 1'b1);
        send_flit(8'h33, 6'd5, 1'b0, 1'b0, 1'b1);
        send_flit(8'h44, 6'd5, 1'b1, 1'b0, 1'b1);
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (axis_tvalid) lat = cyc - last_send_cyc;
        end
        check("t1_tvalid_latency", 64'(lat), 64'(2));
        wait_cycles(5);
        check("t1_credit_pulses", 64'(credit_returns - cr0), 64'(4));

        // Early tail on the second flit; later dest ignored.
        send_flit(8'hAA, 6'd9, 1'b0, 1'b0, 1'b1);
        send_flit(8'hBB, 6'd3, 1'b1, 1'b0, 1'b1);
        wait_cycles(6);
        check("t2_drained", 64'(exp_q.size()), 64'(0));

        // Backpressure: eight flits, output held until tready rises.
        axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_flit(8'(8'h50 + i), 6'(i + 1), (i == 7), 1'b0, 1'b1);
        end
        wait_cycles(10);
        check("t3_tvalid_held", 64'(axis_tvalid), 64'(1));
        check("t3_no_overflow", 64'(overflow_err), 64'(0));
        n0 = hs_q.size();
        axis_tready = 1'b1;
        wait_handshakes(n0 + 2);
        if (hs_q.size() >= n0 + 2) check("t3_b2b_gap", 64'(hs_q[n0 + 1] - hs_q[n0]), 64'(1));
        else check("t3_handshakes", 64'(hs_q.size() - n0), 64'(2));
        wait_cycles(4);

        // Overflow: occupied output, closing flits stall, fifth flit dropped.
        do_reset();
        axis_tready = 1'b0;
        send_flit(8'h01, 6'd1, 1'b1, 1'b0, 1'b1);
        wait_cycles(3);
        check("t4_first_beat_valid", 64'(axis_tvalid), 64'(1));
        for (int i = 0; i < 4; i++) begin
            send_flit(8'(8'h10 + i), 6'(i + 10), 1'b1, 1'b1, 1'b1);
        end
        check("t4_no_overflow_yet", 64'(overflow_err), 64'(0));
        send_flit(8'h14, 6'd14, 1'b1, 1'b1, 1'b0);
        wait_cycles(1);
        check("t4_overflow_set", 64'(overflow_err), 64'(1));
        // Push and pop together on a full FIFO.
        axis_tready = 1'b1;
        send_flit(8'h15, 6'd15, 1'b1, 1'b1, 1'b1);
        wait_cycles(12);
        check("t4_drained", 64'(exp_q.size()), 64'(0));
        check("t4_overflow_sticky", 64'(overflow_err), 64'(1));

        do_reset();
        check_reset_state("reset2");

        // Reset in the middle of a packet.
        send_flit(8'h61, 6'd2, 1'b0, 1'b0, 1'b1);
        send_flit(8'h62, 6'd2, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        wait_cycles(1);
        cr0 = credit_returns;
        wait_cycles(3);
        check("t5_tvalid_in_reset", 64'(axis_tvalid), 64'(0));
        exp_q.delete();
        part_data.delete();
        sent_total  = 0;
        credit_base = credit_returns;
        rst_n = 1'b1;
        wait_cycles(5);
        check("t5_no_credit", 64'(credit_returns - cr0), 64'(0));
        check("t5_tvalid_after", 64'(axis_tvalid), 64'(0));
        send_flit(8'h71, 6'd7, 1'b0, 1'b0, 1'b1);
        send_flit(8'h72, 6'd8, 1'b0, 1'b0, 1'b1);
        send_flit(8'h73, 6'd9, 1'b0, 1'b0, 1'b1);
        send_flit(8'h74, 6'd10, 1'b1, 1'b0, 1'b1);
        wait_cycles(8);
        check("t5_drained", 64'(exp_q.size()), 64'(0));

        // Sustained random flits, no early tails: one beat every SF cycles.
        n0 = hs_q.size();
        for (int i = 0; i < 32; i++) begin
            send_flit(8'($urandom_range(0, 255)), 6'($urandom_range(0, 63)), (i == 31), 1'b0, 1'b1);
        end
        wait_handshakes(n0 + 8);
        if (hs_q.size() >= n0 + 8) begin
            for (int i = 0; i < 7; i++) begin
                check("t6_beat_cadence", 64'(hs_q[n0 + i + 1] - hs_q[n0 + i]), 64'(SF));
            end
        end else begin
            check("t6_handshakes", 64'(hs_q.size() - n0), 64'(8));
        end

        // Random tails, random tready, random idle gaps.
        for (int i = 0; i < 80; i++) begin
            axis_tready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) wait_cycles(1);
            tl = (i == 79) || ($urandom_range(0, 3) == 0);
            send_flit(8'($urandom_range(0, 255)), 6'($urandom_range(0, 63)), tl, 1'b0, 1'b1);
        end
        axis_tready = 1'b1;
        wait_cycles(20);
        check("t7_drained", 64'(exp_q.size()), 64'(0));
        check("t7_no_overflow", 64'(overflow_err), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
